// File: rtl/alu_pkg.sv
// Shared types for the sequential logic/shift unit.
// Holds the opcode and FSM state enums used by seq_logic_alu and shift_step.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_NOT = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_ROL = 3'd6,
        OP_SRA = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/seq_logic_alu_shift_step.sv
// shift_step: combinational 1-bit shift/rotate of an N-bit word.
// Ports: i_op (opcode), i_word (word in), o_word (stepped word), o_cout (bit out).
// Optional macro ARITH_SHIFT_EN adds the sign-replicating SRA step.
module shift_step
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  alu_op_t      i_op,
    input  logic [N-1:0] i_word,
    output logic [N-1:0] o_word,
    output logic         o_cout
);

    always_comb begin
        o_word = {1'b0, i_word[N-1:1]};
        o_cout = i_word[0];
        case (i_op)
            OP_SHL: begin
                o_word = {i_word[N-2:0], 1'b0};
                o_cout = i_word[N-1];
            end
            OP_ROL: begin
                o_word = {i_word[N-2:0], i_word[N-1]};
                o_cout = i_word[N-1];
            end
`ifdef ARITH_SHIFT_EN
            OP_SRA: begin
                o_word = {i_word[N-1], i_word[N-1:1]};
                o_cout = i_word[0];
            end
`endif
            default: begin
                o_word = {1'b0, i_word[N-1:1]};
                o_cout = i_word[0];
            end
        endcase
    end

endmodule

// File: rtl/seq_logic_alu.sv
// seq_logic_alu: registered N-bit logic unit with iterative shifts/rotates.
// Ports: clk, rst (async high); in_valid/in_ready, op, a, b on the operand side;
// out_valid/out_ready, result, flag_z/flag_n/flag_c on the result side.
// Optional macro ARITH_SHIFT_EN: op 7 is SRA; otherwise op 7 acts as SHR.
module seq_logic_alu
    import alu_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c
);

    localparam logic [N-1:0]  NW = N'(N);
    localparam logic [CW-1:0] NC = CW'(N);

    alu_state_t    r_state;
    alu_op_t       r_op;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_result;
    logic [CW-1:0] r_cnt;
    logic          r_z;
    logic          r_n;
    logic          r_c;

    alu_op_t       w_op;
    logic          w_is_shift;
    logic [CW-1:0] w_amt;
    logic [N-1:0]  w_logic;
    logic [N-1:0]  w_step;
    logic          w_cout;

    always_comb begin
        w_op = alu_op_t'(op);
`ifndef ARITH_SHIFT_EN
        if (w_op == OP_SRA) w_op = OP_SHR;
`endif
    end

    assign w_is_shift = op[2];

    // Amount compared at full operand width so large b saturates to N.
    assign w_amt = (b >= NW) ? NC : b[CW-1:0];

    always_comb begin
        w_logic = '0;
        case (w_op)
            OP_AND:  w_logic = a & b;
            OP_OR:   w_logic = a | b;
            OP_XOR:  w_logic = a ^ b;
            OP_NOT:  w_logic = ~a;
            default: w_logic = '0;
        endcase
    end

    shift_step #(.N(N)) u_step (
        .i_op   (r_op),
        .i_word (r_acc),
        .o_word (w_step),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_AND;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_c <= 1'b0;
                        if (w_is_shift) begin
                            r_op  <= w_op;
                            r_acc <= a;
                            r_cnt <= w_amt;
                            if (w_amt == '0) begin
                                r_result <= a;
                                r_z      <= (a == '0);
                                r_n      <= a[N-1];
                                r_state  <= DONE;
                            end else begin
                                r_state <= SHIFT;
                            end
                        end else begin
                            r_result <= w_logic;
                            r_z      <= (w_logic == '0);
                            r_n      <= w_logic[N-1];
                            r_state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    r_acc <= w_step;
                    r_c   <= w_cout;
                    r_cnt <= r_cnt - CW'(1);
                    // Final step: publish result and flags together.
                    if (r_cnt == CW'(1)) begin
                        r_result <= w_step;
                        r_z      <= (w_step == '0);
                        r_n      <= w_step[N-1];
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;

endmodule
